// File: rtl/mips_pipeline_pkg.sv
// Shared types for the MIPS pipeline sequencing logic: forward selects,
// shadow-pipeline entries, scheduler FSM states and instruction field positions.
package mips_pipeline_pkg;

  localparam int REG_W  = 5;
  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;

  typedef enum logic [1:0] {
    FWD_REGFILE   = 2'b00,
    FWD_WRITEBACK = 2'b01,
    FWD_MEMORY    = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } sched_state_t;

  typedef struct packed {
    logic [REG_W-1:0] dest;
    logic             write_en;
    logic             is_load;
  } shadow_t;

  // Execute also remembers its source registers so forwarding can be resolved there
  typedef struct packed {
    shadow_t          info;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
  } ex_shadow_t;

endpackage

// File: rtl/hazard_forward_select.sv
// Operand forward select for one Execute source register; the Memory stage
// result is newer than WriteBack, so it wins when both match.
module hazard_forward_select
  import mips_pipeline_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  shadow_t          mem_entry,
  input  shadow_t          wb_entry,
  output fwd_sel_t         sel
);

  always_comb begin
    sel = FWD_REGFILE;
    if (mem_entry.write_en && (mem_entry.dest != '0) && (mem_entry.dest == src))
      sel = FWD_MEMORY;
    else if (wb_entry.write_en && (wb_entry.dest != '0) && (wb_entry.dest == src))
      sel = FWD_WRITEBACK;
  end

endmodule

// File: rtl/hazard_scheduler_mips.sv
// Pipeline sequencing controller: load-use stalls, branch/jump flushes,
// data-memory freeze, Execute forwarding and saturating debug counters.
module hazard_scheduler_mips
  import mips_pipeline_pkg::*;
#(
  parameter int REG_ADDR_WIDTH    = 5,
  parameter int STALL_COUNT_WIDTH = 32,
  parameter int FLUSH_COUNT_WIDTH = 16
) (
  input  logic                         clock,
  input  logic                         resetMachine,
  input  logic [31:0]                  instruction_Fetch,
  input  logic [REG_ADDR_WIDTH-1:0]    addressWriteRegisterFile_Decode,
  input  logic                         enableWriteRegisterFile_Decode,
  input  logic                         enableReadDataMemory_Decode,
  input  logic                         enableJumpProgramCounter_Decode,
  input  logic                         branchTaken_Execute,
  input  logic                         dataMemoryRequest_Memory,
  input  logic                         dataMemoryReady,
  output logic                         stallFetch_HazardUnit,
  output logic                         controlSignalSendNoOperation_HazardUnit,
  output logic                         flushFetch_HazardUnit,
  output logic                         flushDecode_HazardUnit,
  output logic                         freezePipeline_HazardUnit,
  output logic [1:0]                   forwardA_HazardUnit,
  output logic [1:0]                   forwardB_HazardUnit,
  output logic [STALL_COUNT_WIDTH-1:0] stallCycleCount,
  output logic [FLUSH_COUNT_WIDTH-1:0] flushCount
);

  sched_state_t     state;
  ex_shadow_t       ex_q;
  shadow_t          mem_q;
  shadow_t          wb_q;
  logic [REG_W-1:0] rs_fetch;
  logic [REG_W-1:0] rt_fetch;
  logic             load_use;
  logic             freeze;
  logic             active;
  logic             stall;
  logic             flush_fetch;
  logic             flush_decode;
  fwd_sel_t         fwd_a;
  fwd_sel_t         fwd_b;

  assign rs_fetch = instruction_Fetch[RS_MSB:RS_LSB];
  assign rt_fetch = instruction_Fetch[RT_MSB:RT_LSB];

  assign load_use = ex_q.info.is_load && ex_q.info.write_en && (ex_q.info.dest != '0) &&
                    ((ex_q.info.dest == rs_fetch) || (ex_q.info.dest == rt_fetch));

  // Gating with reset keeps input-driven controls quiet while the machine is held
  assign freeze = resetMachine &&
                  ((dataMemoryRequest_Memory && !dataMemoryReady) ||
                   ((state == MEM_WAIT) && !dataMemoryReady));
  assign active       = resetMachine && !freeze;
  assign flush_decode = active && branchTaken_Execute;
  assign stall        = active && !branchTaken_Execute && load_use;
  assign flush_fetch  = active && (branchTaken_Execute ||
                                   (enableJumpProgramCounter_Decode && !load_use));

  assign stallFetch_HazardUnit                   = stall;
  assign controlSignalSendNoOperation_HazardUnit = stall;
  assign flushFetch_HazardUnit                   = flush_fetch;
  assign flushDecode_HazardUnit                  = flush_decode;
  assign freezePipeline_HazardUnit               = freeze;
  assign forwardA_HazardUnit                     = fwd_a;
  assign forwardB_HazardUnit                     = fwd_b;

  hazard_forward_select u_fwd_a (
    .src       (ex_q.rs),
    .mem_entry (mem_q),
    .wb_entry  (wb_q),
    .sel       (fwd_a)
  );

  hazard_forward_select u_fwd_b (
    .src       (ex_q.rt),
    .mem_entry (mem_q),
    .wb_entry  (wb_q),
    .sel       (fwd_b)
  );

  always_ff @(posedge clock or negedge resetMachine) begin
    if (!resetMachine) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:      if (dataMemoryRequest_Memory && !dataMemoryReady) state <= MEM_WAIT;
        MEM_WAIT: if (dataMemoryReady) state <= RUN;
        default:  state <= RUN;
      endcase
    end
  end

  // A bubble or Decode flush empties Execute while older entries keep draining
  always_ff @(posedge clock or negedge resetMachine) begin
    if (!resetMachine) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (!freeze) begin
      wb_q  <= mem_q;
      mem_q <= ex_q.info;
      if (stall || flush_decode) begin
        ex_q <= '0;
      end else begin
        ex_q.info.dest     <= addressWriteRegisterFile_Decode;
        ex_q.info.write_en <= enableWriteRegisterFile_Decode;
        ex_q.info.is_load  <= enableReadDataMemory_Decode;
        ex_q.rs            <= rs_fetch;
        ex_q.rt            <= rt_fetch;
      end
    end
  end

  always_ff @(posedge clock or negedge resetMachine) begin
    if (!resetMachine) begin
      stallCycleCount <= '0;
      flushCount      <= '0;
    end else begin
      if ((stall || freeze) && (stallCycleCount != '1))
        stallCycleCount <= stallCycleCount + 1'b1;
      if ((flush_fetch || flush_decode) && (flushCount != '1))
        flushCount <= flushCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scheduler_mips.sv
// Scoreboard bench for hazard_scheduler_mips: per-cycle control expectations
// are queued as stimulus is applied and popped when outputs are sampled.
module tb_hazard_scheduler_mips;

  logic        clock = 1'b0;
  logic        resetMachine;
  logic [31:0] instruction_Fetch;
  logic [4:0]  addressWriteRegisterFile_Decode;
  logic        enableWriteRegisterFile_Decode;
  logic        enableReadDataMemory_Decode;
  logic        enableJumpProgramCounter_Decode;
  logic        branchTaken_Execute;
  logic        dataMemoryRequest_Memory;
  logic        dataMemoryReady;
  logic        stallFetch_HazardUnit;
  logic        controlSignalSendNoOperation_HazardUnit;
  logic        flushFetch_HazardUnit;
  logic        flushDecode_HazardUnit;
  logic        freezePipeline_HazardUnit;
  logic [1:0]  forwardA_HazardUnit;
  logic [1:0]  forwardB_HazardUnit;
  logic [31:0] stallCycleCount;
  logic [15:0] flushCount;

  hazard_scheduler_mips dut (
    .clock                                   (clock),
    .resetMachine                            (resetMachine),
    .instruction_Fetch                       (instruction_Fetch),
    .addressWriteRegisterFile_Decode         (addressWriteRegisterFile_Decode),
    .enableWriteRegisterFile_Decode          (enableWriteRegisterFile_Decode),
    .enableReadDataMemory_Decode             (enableReadDataMemory_Decode),
    .enableJumpProgramCounter_Decode         (enableJumpProgramCounter_Decode),
    .branchTaken_Execute                     (branchTaken_Execute),
    .dataMemoryRequest_Memory                (dataMemoryRequest_Memory),
    .dataMemoryReady                         (dataMemoryReady),
    .stallFetch_HazardUnit                   (stallFetch_HazardUnit),
    .controlSignalSendNoOperation_HazardUnit (controlSignalSendNoOperation_HazardUnit),
    .flushFetch_HazardUnit                   (flushFetch_HazardUnit),
    .flushDecode_HazardUnit                  (flushDecode_HazardUnit),
    .freezePipeline_HazardUnit               (freezePipeline_HazardUnit),
    .forwardA_HazardUnit                     (forwardA_HazardUnit),
    .forwardB_HazardUnit                     (forwardB_HazardUnit),
    .stallCycleCount                         (stallCycleCount),
    .flushCount                              (flushCount)
  );

  always #5 clock = ~clock;

  // Control vector layout: {stall, noop, flushFetch, flushDecode, freeze, fwdA, fwdB}
  localparam logic [8:0] E_IDLE  = 9'b00000_00_00;
  localparam logic [8:0] E_STALL = 9'b11000_00_00;
  localparam logic [8:0] E_BR    = 9'b00110_00_00;
  localparam logic [8:0] E_JMP   = 9'b00100_00_00;
  localparam logic [8:0] E_FRZ   = 9'b00001_00_00;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dest;
    logic       we;
    logic       ld;
    logic       jmp;
    logic       br;
    logic       req;
    logic       rdy;
    logic [8:0] exp;
  } stim_t;

  logic [8:0] ctl;
  logic [8:0] want;
  logic [8:0] sb[$];
  int         checks = 0;
  int         fails  = 0;

  assign ctl = {stallFetch_HazardUnit, controlSignalSendNoOperation_HazardUnit,
                flushFetch_HazardUnit, flushDecode_HazardUnit, freezePipeline_HazardUnit,
                forwardA_HazardUnit, forwardB_HazardUnit};

  function automatic stim_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dest,
                               input logic we, input logic ld, input logic jmp, input logic br,
                               input logic req, input logic rdy, input logic [8:0] exp);
    stim_t s;
    s = '{rs: rs, rt: rt, dest: dest, we: we, ld: ld, jmp: jmp, br: br,
          req: req, rdy: rdy, exp: exp};
    return s;
  endfunction

  task automatic set_inputs(input stim_t s);
    instruction_Fetch               = {6'd0, s.rs, s.rt, 16'd0};
    addressWriteRegisterFile_Decode = s.dest;
    enableWriteRegisterFile_Decode  = s.we;
    enableReadDataMemory_Decode     = s.ld;
    enableJumpProgramCounter_Decode = s.jmp;
    branchTaken_Execute             = s.br;
    dataMemoryRequest_Memory        = s.req;
    dataMemoryReady                 = s.rdy;
  endtask

  task automatic step(input stim_t s);
    @(posedge clock);
    #1;
    set_inputs(s);
    sb.push_back(s.exp);
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      set_inputs('0);
    end
  endtask

  task automatic test_reset();
    resetMachine = 1'b0;
    set_inputs(mk(5'd9, 5'd9, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, E_IDLE));
    #2;
    checks++;
    if (ctl !== E_IDLE) begin fails++; $display("[TB] FAIL reset_ctl: got %b expected %b", ctl, E_IDLE); end
    checks++;
    if (stallCycleCount !== 32'd0) begin fails++; $display("[TB] FAIL reset_stall_cnt: got %0d expected 0", stallCycleCount); end
    checks++;
    if (flushCount !== 16'd0) begin fails++; $display("[TB] FAIL reset_flush_cnt: got %0d expected 0", flushCount); end
    @(negedge clock);
    set_inputs('0);
    resetMachine = 1'b1;
  endtask

  task automatic test_load_use();
    stim_t t[$];
    drain();
    t.push_back(mk(5'd29, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE));
    t.push_back(mk(5'd9, 5'd10, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_STALL));
    t.push_back(mk(5'd9, 5'd10, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE));
    t.push_back(mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b00000_01_00));
    foreach (t[i]) begin
      step(t[i]);
      @(negedge clock);
      want = sb.pop_front();
      checks++;
      if (ctl !== want) begin fails++; $display("[TB] FAIL load_use c%0d: got %b expected %b", i, ctl, want); end
    end
    checks++;
    if (stallCycleCount !== 32'd1) begin fails++; $display("[TB] FAIL load_use_stall_cnt: got %0d expected 1", stallCycleCount); end
  endtask

  task automatic test_forwarding();
    stim_t t[$];
    drain();
    t.push_back(mk(5'd1, 5'd2, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE));
    t.push_back(mk(5'd4, 5'd5, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE));
    t.push_back(mk(5'd8, 5'd8, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE));
    t.push_back(mk(5'd8, 5'd3, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b00000_10_10));
    t.push_back(mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b00000_01_00));
    foreach (t[i]) begin
      step(t[i]);
      @(negedge clock);
      want = sb.pop_front();
      checks++;
      if (ctl !== want) begin fails++; $display("[TB] FAIL forwarding c%0d: got %b expected %b", i, ctl, want); end
    end
  endtask

  task automatic test_zero_dest();
    stim_t t[$];
    drain();
    t.push_back(mk(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE));
    t.push_back(mk(5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE));
    t.push_back(mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE));
    foreach (t[i]) begin
      step(t[i]);
      @(negedge clock);
      want = sb.pop_front();
      checks++;
      if (ctl !== want) begin fails++; $display("[TB] FAIL zero_dest c%0d: got %b expected %b", i, ctl, want); end
    end
    checks++;
    if (stallCycleCount !== 32'd1) begin fails++; $display("[TB] FAIL zero_dest_stall_cnt: got %0d expected 1", stallCycleCount); end
  endtask

  task automatic test_freeze();
    stim_t t[$];
    drain();
    t.push_back(mk(5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE));
    for (int i = 0; i < 3; i++)
      t.push_back(mk(5'd7, 5'd7, 5'd14, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, E_FRZ));
    t.push_back(mk(5'd7, 5'd7, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, E_IDLE));
    t.push_back(mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b00000_10_10));
    foreach (t[i]) begin
      step(t[i]);
      @(negedge clock);
      want = sb.pop_front();
      checks++;
      if (ctl !== want) begin fails++; $display("[TB] FAIL freeze c%0d: got %b expected %b", i, ctl, want); end
    end
    checks++;
    if (stallCycleCount !== 32'd4) begin fails++; $display("[TB] FAIL freeze_stall_cnt: got %0d expected 4", stallCycleCount); end
    checks++;
    if (flushCount !== 16'd0) begin fails++; $display("[TB] FAIL freeze_flush_cnt: got %0d expected 0", flushCount); end
  endtask

  task automatic test_branch_over_stall();
    stim_t t[$];
    drain();
    t.push_back(mk(5'd0, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE));
    t.push_back(mk(5'd9, 5'd0, 5'd11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, E_BR));
    t.push_back(mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE));
    foreach (t[i]) begin
      step(t[i]);
      @(negedge clock);
      want = sb.pop_front();
      checks++;
      if (ctl !== want) begin fails++; $display("[TB] FAIL branch c%0d: got %b expected %b", i, ctl, want); end
    end
    checks++;
    if (flushCount !== 16'd1) begin fails++; $display("[TB] FAIL branch_flush_cnt: got %0d expected 1", flushCount); end
    checks++;
    if (stallCycleCount !== 32'd4) begin fails++; $display("[TB] FAIL branch_stall_cnt: got %0d expected 4", stallCycleCount); end
  endtask

  task automatic test_jump();
    stim_t t[$];
    drain();
    t.push_back(mk(5'd0, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE));
    t.push_back(mk(5'd9, 5'd0, 5'd11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, E_STALL));
    t.push_back(mk(5'd9, 5'd0, 5'd11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, E_JMP));
    t.push_back(mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b00000_01_00));
    foreach (t[i]) begin
      step(t[i]);
      @(negedge clock);
      want = sb.pop_front();
      checks++;
      if (ctl !== want) begin fails++; $display("[TB] FAIL jump c%0d: got %b expected %b", i, ctl, want); end
    end
    checks++;
    if (flushCount !== 16'd2) begin fails++; $display("[TB] FAIL jump_flush_cnt: got %0d expected 2", flushCount); end
    checks++;
    if (stallCycleCount !== 32'd5) begin fails++; $display("[TB] FAIL jump_stall_cnt: got %0d expected 5", stallCycleCount); end
  endtask

  task automatic test_reset_mid_wait();
    drain();
    for (int i = 0; i < 2; i++) begin
      step(mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, E_FRZ));
      @(negedge clock);
      want = sb.pop_front();
      checks++;
      if (ctl !== want) begin fails++; $display("[TB] FAIL mid_wait c%0d: got %b expected %b", i, ctl, want); end
    end
    #1;
    resetMachine = 1'b0;
    #1;
    checks++;
    if (ctl !== E_IDLE) begin fails++; $display("[TB] FAIL mid_wait_reset_ctl: got %b expected %b", ctl, E_IDLE); end
    checks++;
    if (stallCycleCount !== 32'd0) begin fails++; $display("[TB] FAIL mid_wait_reset_stall_cnt: got %0d expected 0", stallCycleCount); end
    @(posedge clock);
    #1;
    set_inputs('0);
    @(negedge clock);
    resetMachine = 1'b1;
    step(mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE));
    @(negedge clock);
    want = sb.pop_front();
    checks++;
    if (ctl !== want) begin fails++; $display("[TB] FAIL after_reset_run: got %b expected %b", ctl, want); end
    checks++;
    if (stallCycleCount !== 32'd0) begin fails++; $display("[TB] FAIL after_reset_stall_cnt: got %0d expected 0", stallCycleCount); end
    checks++;
    if (flushCount !== 16'd0) begin fails++; $display("[TB] FAIL after_reset_flush_cnt: got %0d expected 0", flushCount); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_forwarding();
    test_zero_dest();
    test_freeze();
    test_branch_over_stall();
    test_jump();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/hazard_scheduler_mips.md
# hazard_scheduler_mips

Pipeline sequencing controller for the 5-stage MIPS core. It keeps its own shadow copy of destination and source register info for Execute, Memory and WriteBack, and drives four groups of control:
- stall and bubble controls into Fetch and Decode;
- flush controls for jumps and taken branches;
- whole-pipeline freeze while data memory is busy;
- operand forwarding selects for Execute.

It also keeps saturating stall and flush counters for performance debug.

## Interface
- REG_ADDR_WIDTH, 5, register-file address width
- STALL_COUNT_WIDTH, 32, width of stall-cycle counter
- FLUSH_COUNT_WIDTH, 16, width of flush counter

Ports:
- clock  in  1  pipeline clock, rising edge
- resetMachine  in  1  reset, asynchronous, active-low
- instruction_Fetch  in  32  instruction entering Decode; rs=[25:21], rt=[20:16]
- addressWriteRegisterFile_Decode  in  5  Decode-stage destination (post R/I mux)
- enableWriteRegisterFile_Decode  in  1  Decode-stage write enable
- enableReadDataMemory_Decode  in  1  Decode-stage instruction is a load
- enableJumpProgramCounter_Decode  in  1  jump resolved in Decode
- branchTaken_Execute  in  1  branch resolved taken in Execute
- dataMemoryRequest_Memory  in  1  Memory stage is accessing data memory
- dataMemoryReady  in  1  data memory completes access this cycle
- stallFetch_HazardUnit  out  1  hold PC and Fetch/Decode register
- controlSignalSendNoOperation_HazardUnit  out  1  load bubble into Decode/Execute register
- flushFetch_HazardUnit  out  1  squash instruction in Fetch/Decode register
- flushDecode_HazardUnit  out  1  squash Decode/Execute register
- freezePipeline_HazardUnit  out  1  hold every stage register
- forwardA_HazardUnit  out  2  Execute operand A select: 00 RF, 01 WriteBack, 10 Memory
- forwardB_HazardUnit  out  2  Execute operand B select, same encoding
- stallCycleCount  out  STALL_COUNT_WIDTH  saturating count of stall or freeze cycles
- flushCount  out  FLUSH_COUNT_WIDTH  saturating count of flush events

## Operation
- Shadow pipeline: three registered entries, EX, MEM and WB.
  - Each entry holds {dest, writeEnable, isLoad}. The EX entry also holds rs and rt.
  - The EX entry loads from the Decode inputs and instruction_Fetch fields.
  - MEM loads from EX, and WB loads from MEM.
- Shadow update rules, evaluated in this order:
  - freeze: all entries hold.
  - bubble or flushDecode: EX loads zeros; MEM and WB still advance.
  - otherwise: all entries advance.
- Load-use hazard: the EX entry has isLoad=1, writeEnable=1, dest≠0, and dest equals rs or rt of instruction_Fetch.
  - rt is compared unconditionally (conservative).
  - Response: stallFetch_HazardUnit=1 and controlSignalSendNoOperation_HazardUnit=1 for exactly one cycle.
- Forwarding for operand A, using the EX rs:
  - 10 when MEM writeEnable=1, MEM dest≠0 and MEM dest==rs.
  - else 01 when the same conditions hold for WB.
  - else 00.
  - Memory has priority over WriteBack.
- Operand B: same rule using the EX rt.
- Taken branch (branchTaken_Execute=1): flushFetch_HazardUnit=1 and flushDecode_HazardUnit=1. This overrides any load-use stall in the same cycle.
- Jump (enableJumpProgramCounter_Decode=1, no taken branch): flushFetch_HazardUnit=1 only.
  - If a load-use stall is active in the same cycle, the jump is not honoured. The flush waits until the stall clears, because the jump re-presents.
- FSM with two states, RUN and MEM_WAIT:
  - RUN→MEM_WAIT when dataMemoryRequest_Memory=1 and dataMemoryReady=0.
  - MEM_WAIT→RUN when dataMemoryReady=1.
- freezePipeline_HazardUnit = (dataMemoryRequest_Memory & ~dataMemoryReady) | (state==MEM_WAIT & ~dataMemoryReady).
- While frozen, all other stall, flush and bubble outputs are forced to 0, and the shadows hold.
- Priority: freeze > branch flush > load-use stall > jump flush.
- Counters:
  - stallCycleCount increments in every cycle where stallFetch_HazardUnit or freezePipeline_HazardUnit is 1.
  - flushCount increments once per cycle in which either flush output is 1.
  - Both saturate at all-ones and never wrap.

## Timing
- All control outputs are combinational from shadow state, FSM state and inputs, so they act in the same cycle.
- Shadows, FSM and counters update on the clock rising edge.
- While resetMachine=0, asynchronously:
  - all shadow entries are zero and the FSM is in RUN;
  - both counters are zero;
  - every control output is 0, and both forward selects are 00.
- Reset asserted mid-freeze or mid-stall drops all controls to 0 immediately.
- Load-use latency: at stall cycle t, the dependent instruction is held. At t+2 it sits in Execute with forwardX=01 from WriteBack.
- MEM_WAIT has no timeout. The freeze persists until dataMemoryReady is 1.

## Structure
- Shared package mips_pipeline_pkg holds:
  - a forward-select enum: FWD_REGFILE=2'b00, FWD_WRITEBACK=2'b01, FWD_MEMORY=2'b10;
  - the shadow-entry struct;
  - the FSM state enum;
  - constants for the rs and rt bit positions.
- One natural sub-module, hazard_forward_select. It is combinational and is instantiated twice, once for operand A and once for operand B.

## Test plan
- Load $t1 (dest 9) followed by add using rs=9: exactly one cycle with stall=1 and noop=1. Two cycles later, forwardA=01. stallCycleCount=1.
- Back-to-back add writing $8, then an instruction reading rs=8 and rt=8: forwardA=forwardB=10 in Execute. The next instruction reading $8 gets 01.
- Dest=0 with write enable and a matching rs=0: no stall, forwardA=00.
- dataMemoryRequest=1 with ready low for 3 cycles: freeze=1 for 3 cycles, no flush despite branchTaken=1, then state returns to RUN. stallCycleCount=3.
- Taken branch in the same cycle as a load-use hazard: flushFetch=flushDecode=1, stall=0, flushCount increments by 1.
- Reset pulled low during MEM_WAIT: all outputs 0 at once. After release, the first cycle is in RUN with counters at 0.
